// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx between NUM_REQ byte sources, with packet lock.
// Latency: valid sampled in IDLE -> tx_en_o/req_ready_o one clock later; a sampled busy fall reopens IDLE after GAP_CYCLES clocks.
// Backpressure: a source holds valid/data until its one-cycle req_ready_o pulse; valids are sampled only in IDLE.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 5208,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 tx_en_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BT_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PTR_W:0]   NREQ_W   = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d, owner_inc;
    logic               lock_q, lock_d;
    logic               last_q, last_d;
    logic [BT_W-1:0]    bcnt_q, bcnt_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic [NUM_REQ-1:0] ready_d, grant_d;
    logic               tx_en_d, err_d;
    logic [7:0]         tx_data_d;

    logic               cand_vld;
    logic [PTR_W-1:0]   cand_idx;
    logic [PTR_W:0]     scan_idx;

    assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // Scan downwards so the entry nearest rr_ptr is written last and wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        scan_idx = '0;
        if (lock_q) begin
            cand_vld = req_valid_i[owner_q];
            cand_idx = owner_q;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                if (scan_idx >= NREQ_W) begin
                    scan_idx = scan_idx - NREQ_W;
                end
                if (req_valid_i[scan_idx[PTR_W-1:0]]) begin
                    cand_vld = 1'b1;
                    cand_idx = scan_idx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        last_d    = last_q;
        bcnt_d    = bcnt_q;
        gcnt_d    = gcnt_q;
        ready_d   = '0;
        grant_d   = grant_o;
        tx_en_d   = 1'b0;
        err_d     = 1'b0;
        tx_data_d = tx_data_o;
        case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    state_d   = WAIT_BUSY;
                    owner_d   = cand_idx;
                    last_d    = req_last_i[cand_idx];
                    ready_d   = NUM_REQ'(1) << cand_idx;
                    grant_d   = NUM_REQ'(1) << cand_idx;
                    tx_en_d   = 1'b1;
                    tx_data_d = req_data_i[{cand_idx, 3'b000} +: 8];
                    bcnt_d    = '0;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (bcnt_q == BT_LAST) begin
                    err_d    = 1'b1;
                    lock_d   = 1'b0;
                    grant_d  = '0;
                    rr_ptr_d = owner_inc;
                    gcnt_d   = GAP_LOAD;
                    state_d  = GAP;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = GAP;
                    gcnt_d  = GAP_LOAD;
                    if (last_q) begin
                        lock_d   = 1'b0;
                        grant_d  = '0;
                        rr_ptr_d = owner_inc;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            GAP: begin
                // Leaving one clock early makes the IDLE sampling edge land GAP_CYCLES after the fall.
                if (gcnt_q <= GAP_ONE) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_q      <= 1'b0;
            last_q      <= 1'b0;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            req_ready_o <= '0;
            grant_o     <= '0;
            tx_en_o     <= 1'b0;
            tx_data_o   <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            req_ready_o <= ready_d;
            grant_o     <= grant_d;
            tx_en_o     <= tx_en_d;
            tx_data_o   <= tx_data_d;
            busy_o      <= (state_d != IDLE);
            err_o       <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: time-based reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 3;
    localparam int BT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        tx_busy = 1'b0;
    logic [3:0]  req_ready_o, grant_o;
    logic        tx_en_o, busy_o, err_o;
    logic [7:0]  tx_data_o;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready_o), .grant_o(grant_o),
        .tx_en_o(tx_en_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester sources: each queue entry is {last, data}
    logic [8:0] src_q [NREQ][$];
    always @(negedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready_o[k] === 1'b1 && src_q[k].size() > 0) void'(src_q[k].pop_front());
            req_valid[k]       = (src_q[k].size() > 0);
            req_last[k]        = (src_q[k].size() > 0) ? src_q[k][0][8] : 1'b0;
            req_data[8*k +: 8] = (src_q[k].size() > 0) ? src_q[k][0][7:0] : 8'h00;
        end
    end

    // Transmitter stand-in: rises in the tx_en cycle and stays high for busy_len sampled edges
    bit busy_auto = 1'b1;
    int busy_len = 100;
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            tx_busy = 1'b0;
            busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (busy_auto && tx_en_o === 1'b1) begin
            tx_busy = 1'b1;
            busy_cnt = busy_len;
        end
    end

    // Reference model in absolute edge times
    bit   m_inflight, m_risen, m_lock, m_last;
    int   m_owner, m_ptr, m_issue, m_next_ok;
    logic [3:0] e_ready, e_grant;
    logic       e_en, e_busy, e_err;
    logic [7:0] e_data;

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        int k;
        cyc++;
        if (rst) begin
            m_inflight = 0; m_risen = 0; m_lock = 0; m_last = 0;
            m_owner = 0; m_ptr = 0; m_issue = 0; m_next_ok = 0;
            e_ready = '0; e_grant = '0; e_en = 0; e_busy = 0; e_err = 0; e_data = '0;
        end else begin
            e_ready = '0; e_en = 0; e_err = 0;
            if (!m_inflight) begin
                if (cyc >= m_next_ok) begin
                    if (m_lock) k = req_valid[m_owner] ? m_owner : -1;
                    else        k = pick(req_valid, m_ptr);
                    if (k >= 0) begin
                        m_inflight = 1; m_risen = 0; m_issue = cyc; m_owner = k;
                        m_last = req_last[k];
                        e_ready = 4'b0001 << k; e_grant = 4'b0001 << k;
                        e_en = 1; e_data = req_data[8*k +: 8];
                    end
                end
            end else if (!m_risen) begin
                if (tx_busy) m_risen = 1;
                else if (cyc - m_issue == BT) begin
                    e_err = 1; m_lock = 0; e_grant = '0;
                    m_ptr = (m_owner + 1) % NREQ;
                    m_inflight = 0; m_next_ok = cyc + GAP;
                end
            end else if (!tx_busy) begin
                m_inflight = 0; m_next_ok = cyc + GAP;
                if (m_last) begin
                    m_lock = 0; e_grant = '0; m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    m_lock = 1;
                end
            end
            e_busy = m_inflight || (cyc + 1 < m_next_ok);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("req_ready", req_ready_o, e_ready);
            chk("grant", grant_o, e_grant);
            chk("tx_en", tx_en_o, e_en);
            chk("tx_data", tx_data_o, e_data);
            chk("busy", busy_o, e_busy);
            chk("err", err_o, e_err);
        end
    end

    // Issue log and error log for the directed checks
    logic [7:0] log_data [$];
    logic [3:0] log_grant [$];
    logic [3:0] log_ready [$];
    int         log_cyc [$];
    int err_cnt = 0;
    int err_cyc = 0;
    always @(negedge clk) begin
        if (!rst && tx_en_o === 1'b1) begin
            log_data.push_back(tx_data_o);
            log_grant.push_back(grant_o);
            log_ready.push_back(req_ready_o);
            log_cyc.push_back(cyc);
        end
        if (!rst && err_o === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic wait_log(input int n, input int budget, input string name);
        int b = budget;
        while (log_data.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk(name, (log_data.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int b = budget;
        bit done = 0;
        while (!done && b > 0) begin
            @(negedge clk);
            b--;
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
                   (src_q[2].size() == 0) && (src_q[3].size() == 0) && (busy_o === 1'b0);
        end
        chk(name, done, 1);
    endtask

    initial begin
        int b;
        repeat (3) @(negedge clk);
        chk("reset_grant", grant_o, 4'b0000);
        chk("reset_tx_en", tx_en_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        rst = 1'b0;

        // Single byte from req0
        busy_len = 100;
        b = log_data.size();
        src_q[0].push_back({1'b1, 8'hA5});
        wait_log(b + 1, 20, "single_issue_timeout");
        chk("single_data", log_data[b], 8'hA5);
        chk("single_ready", log_ready[b], 4'b0001);
        chk("single_grant", log_grant[b], 4'b0001);
        wait_idle(200, "single_idle_timeout");
        chk("single_grant_after", grant_o, 4'b0000);

        // Round-robin between req1 and req2, valids held continuously
        busy_len = 5;
        b = log_data.size();
        src_q[1].push_back({1'b1, 8'h11});
        src_q[1].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h22});
        src_q[2].push_back({1'b1, 8'h22});
        wait_log(b + 4, 100, "rr_issue_timeout");
        chk("rr_0", log_data[b],     8'h11);
        chk("rr_1", log_data[b + 1], 8'h22);
        chk("rr_2", log_data[b + 2], 8'h11);
        chk("rr_3", log_data[b + 3], 8'h22);
        chk("gap_sep_1", log_cyc[b + 1] - log_cyc[b],     5 + GAP + 1);
        chk("gap_sep_2", log_cyc[b + 2] - log_cyc[b + 1], 5 + GAP + 1);
        chk("gap_sep_3", log_cyc[b + 3] - log_cyc[b + 2], 5 + GAP + 1);
        wait_idle(100, "rr_idle_timeout");

        // Packet lock: req0 three-byte packet while req3 waits
        b = log_data.size();
        src_q[0].push_back({1'b0, 8'hA0});
        src_q[0].push_back({1'b0, 8'hA1});
        src_q[0].push_back({1'b1, 8'hA2});
        wait_log(b + 1, 20, "lock_first_timeout");
        src_q[3].push_back({1'b1, 8'hD3});
        wait_log(b + 4, 100, "lock_issue_timeout");
        chk("lock_0", log_data[b],     8'hA0);
        chk("lock_1", log_data[b + 1], 8'hA1);
        chk("lock_2", log_data[b + 2], 8'hA2);
        chk("lock_3", log_data[b + 3], 8'hD3);
        chk("lock_g1", log_grant[b + 1], 4'b0001);
        chk("lock_g2", log_grant[b + 2], 4'b0001);
        chk("lock_g3", log_grant[b + 3], 4'b1000);
        wait_idle(100, "lock_idle_timeout");

        // Busy timeout on a req2 issue, then req3 takes priority over req0
        busy_auto = 1'b0;
        b = log_data.size();
        src_q[2].push_back({1'b1, 8'hC2});
        wait_log(b + 1, 20, "to_issue_timeout");
        src_q[3].push_back({1'b1, 8'hE3});
        src_q[0].push_back({1'b1, 8'hE0});
        begin
            int w = 40;
            while (err_cnt == 0 && w > 0) begin
                @(negedge clk);
                w--;
            end
        end
        chk("to_err_seen", err_cnt, 1);
        chk("to_err_delay", err_cyc - log_cyc[b], BT);
        busy_auto = 1'b1;
        wait_log(b + 3, 100, "to_next_timeout");
        chk("to_next_0", log_data[b + 1], 8'hE3);
        chk("to_next_1", log_data[b + 2], 8'hE0);
        wait_idle(100, "to_idle_timeout");
        chk("to_err_once", err_cnt, 1);

        // Reset during WAIT_DONE of a locked packet
        busy_len = 20;
        b = log_data.size();
        src_q[1].push_back({1'b0, 8'h51});
        src_q[1].push_back({1'b1, 8'h52});
        wait_log(b + 2, 100, "rst_issue_timeout");
        repeat (5) @(negedge clk);
        chk("rst_pre_grant", grant_o, 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_grant", grant_o, 4'b0000);
        chk("rst_tx_en", tx_en_o, 1'b0);
        chk("rst_tx_data", tx_data_o, 8'h00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", req_ready_o, 4'b0000);
        rst = 1'b0;
        b = log_data.size();
        src_q[0].push_back({1'b1, 8'h60});
        src_q[1].push_back({1'b1, 8'h61});
        wait_log(b + 2, 100, "post_rst_timeout");
        chk("post_rst_0", log_data[b], 8'h60);
        chk("post_rst_g0", log_grant[b], 4'b0001);
        chk("post_rst_1", log_data[b + 1], 8'h61);
        wait_idle(100, "post_rst_idle_timeout");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
